// File: rtl/sprite_pkg.sv
// Shared geometry, glyph codes, streamer state encoding and the glyph artwork
// used to build the default ROM image for sprite_row_streamer.
package sprite_pkg;

  localparam int GLYPH_W    = 24;
  localparam int GLYPH_H    = 22;
  localparam int NUM_GLYPHS = 13;
  localparam int CODE_W     = 4;
  localparam int ROW_W      = 5;
  localparam int COL_W      = 5;

  localparam int GLY_BLANK     = 0;
  localparam int GLY_FROG_UP   = 1;
  localparam int GLY_FROG_DOWN = 2;
  localparam int GLY_FROG_R    = 3;
  localparam int GLY_FROG_L    = 4;
  localparam int GLY_S         = 5;
  localparam int GLY_C         = 6;
  localparam int GLY_O         = 7;
  localparam int GLY_R         = 8;
  localparam int GLY_E         = 9;
  localparam int GLY_COLON     = 10;
  localparam int GLY_ZERO      = 11;
  localparam int GLY_SOLID     = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } stream_state_t;

  localparam logic [GLYPH_W-1:0] BAR = 24'h3FFFFC;
  localparam logic [GLYPH_W-1:0] LFT = 24'h3C0000;
  localparam logic [GLYPH_W-1:0] RGT = 24'h00003C;
  localparam logic [GLYPH_W-1:0] MID = 24'h00FF00;

  function automatic logic [GLYPH_W-1:0] reverse_row(input logic [GLYPH_W-1:0] w);
    logic [GLYPH_W-1:0] r;
    for (int i = 0; i < GLYPH_W; i++) r[i] = w[GLYPH_W-1-i];
    return r;
  endfunction

  function automatic logic [GLYPH_W-1:0] frog_up_row(input int row);
    if (row == 0 || row == 20) return 24'h78001E;
    if (row == 1)              return 24'h38001E;
    if (row == 21)             return 24'h70000E;
    if (row >= 2 && row <= 4)  return 24'h0FFFF0;
    if (row >= 5 && row <= 7)  return 24'h3E7E7C;
    if (row >= 8 && row <= 16) return 24'h3FFFFC;
    if (row >= 17 && row <= 19) return 24'h1FFFF8;
    return '0;
  endfunction

  // Letters share one block layout: top/mid/bottom bars and left/right strokes.
  function automatic int band_of(input int row);
    if (row >= 2 && row <= 4)   return 1;
    if (row >= 5 && row <= 9)   return 2;
    if (row == 10 || row == 11) return 3;
    if (row >= 12 && row <= 16) return 4;
    if (row >= 17 && row <= 19) return 5;
    return 0;
  endfunction

  function automatic logic [GLYPH_W-1:0] glyph_row(input int code, input int row);
    logic [GLYPH_W-1:0] w;
    logic [GLYPH_W-1:0] fr;
    int band;
    w    = '0;
    band = band_of(row);
    fr   = frog_up_row(row);
    case (code)
      GLY_FROG_UP:   w = fr;
      GLY_FROG_DOWN: w = frog_up_row(GLYPH_H-1-row);
      GLY_FROG_R:    w = {fr[GLYPH_W-5:0], fr[GLYPH_W-1:GLYPH_W-4]};
      GLY_FROG_L:    w = reverse_row({fr[GLYPH_W-5:0], fr[GLYPH_W-1:GLYPH_W-4]});
      GLY_S:    w = (band == 1 || band == 3 || band == 5) ? BAR :
                    (band == 2) ? LFT : (band == 4) ? RGT : '0;
      GLY_C:    w = (band == 1 || band == 5) ? BAR : (band != 0) ? LFT : '0;
      GLY_O:    w = (band == 1 || band == 5) ? BAR : (band != 0) ? (LFT | RGT) : '0;
      GLY_R:    w = (band == 1 || band == 3) ? BAR : (band == 2) ? (LFT | RGT) :
                    (band != 0) ? (LFT | 24'h000F00) : '0;
      GLY_E:    w = (band == 1 || band == 3 || band == 5) ? BAR : (band != 0) ? LFT : '0;
      GLY_COLON: w = ((row >= 5 && row <= 8) || (row >= 13 && row <= 16)) ? 24'h07E000 : '0;
      GLY_ZERO: w = (band == 1 || band == 5) ? BAR : (band == 3) ? (LFT | MID | RGT) :
                    (band != 0) ? (LFT | RGT) : '0;
      GLY_SOLID: w = '1;
      default:  w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [NUM_GLYPHS*GLYPH_H*GLYPH_W-1:0] build_rom();
    logic [NUM_GLYPHS*GLYPH_H*GLYPH_W-1:0] img;
    img = '0;
    for (int g = 0; g < NUM_GLYPHS; g++)
      for (int r = 0; r < GLYPH_H; r++)
        img[(g*GLYPH_H + r)*GLYPH_W +: GLYPH_W] = glyph_row(g, r);
    return img;
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// Synchronous-read glyph ROM, one registered cycle of latency; addresses past
// the stored image read back as zero.
module glyph_rom
  import sprite_pkg::*;
#(
  parameter int WIDTH  = GLYPH_W,
  parameter int DEPTH  = NUM_GLYPHS * GLYPH_H,
  parameter int ADDR_W = 10,
  parameter logic [DEPTH*WIDTH-1:0] CONTENTS = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign mem[i] = CONTENTS[i*WIDTH +: WIDTH];
  end

  assign in_range = ({1'b0, addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    data <= in_range ? mem[addr[IDX_W-1:0]] : '0;
  end

endmodule

// File: rtl/sprite_row_streamer.sv
// Streams one glyph row out a pixel per handshake, leftmost first, with
// per-request horizontal/vertical mirroring and out-of-range detection.
module sprite_row_streamer
  import sprite_pkg::*;
#(
  parameter int GLYPH_W    = sprite_pkg::GLYPH_W,
  parameter int GLYPH_H    = sprite_pkg::GLYPH_H,
  parameter int NUM_GLYPHS = sprite_pkg::NUM_GLYPHS,
  parameter int CODE_W     = sprite_pkg::CODE_W,
  parameter int ROW_W      = sprite_pkg::ROW_W,
  parameter int COL_W      = sprite_pkg::COL_W,
  parameter logic [NUM_GLYPHS*GLYPH_H*GLYPH_W-1:0] ROM_IMAGE = sprite_pkg::build_rom()
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  input  logic [ROW_W-1:0]  req_row,
  input  logic              req_hflip,
  input  logic              req_vflip,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [COL_W-1:0]  pix_col,
  output logic              pix_last,
  output logic              err_oob,
  output logic              busy
);

  // Wide enough for any code*GLYPH_H+row, so out-of-range codes cannot alias.
  localparam int ADDR_W = CODE_W + ROW_W + 1;
  localparam int DEPTH  = NUM_GLYPHS * GLYPH_H;
  localparam logic [CODE_W:0]    CODE_LIMIT = (CODE_W+1)'(NUM_GLYPHS);
  localparam logic [ROW_W:0]     ROW_LIMIT  = (ROW_W+1)'(GLYPH_H);
  localparam logic [ROW_W-1:0]   ROW_MAX    = ROW_W'(GLYPH_H - 1);
  localparam logic [COL_W-1:0]   COL_MAX    = COL_W'(GLYPH_W - 1);

  stream_state_t state, next_state;

  logic               accept;
  logic               req_oob;
  logic [ROW_W-1:0]   eff_row;
  logic [ADDR_W-1:0]  rom_addr;
  logic [GLYPH_W-1:0] rom_row_p1;
  logic               hflip_p1;
  logic               oob_p1;
  logic [GLYPH_W-1:0] row_p2;

  // Stage 0: request decode and ROM address
  assign accept   = req_valid && req_ready;
  assign req_oob  = ({1'b0, req_code} >= CODE_LIMIT) || ({1'b0, req_row} >= ROW_LIMIT);
  assign eff_row  = req_vflip ? (ROW_MAX - req_row) : req_row;
  assign rom_addr = ADDR_W'(req_code) * ADDR_W'(GLYPH_H) + ADDR_W'(eff_row);

  glyph_rom #(
    .WIDTH   (GLYPH_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .CONTENTS(ROM_IMAGE)
  ) u_glyph_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(rom_row_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = FETCH;
      FETCH:   next_state = SHIFT;
      SHIFT:   if (pix_ready && pix_last) next_state = accept ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 1'b0;
    pix_last  = 1'b0;
    err_oob   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:  req_ready = 1'b1;
      FETCH: begin
        busy    = 1'b1;
        err_oob = oob_p1;
      end
      SHIFT: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        pix_last  = (pix_col == COL_MAX);
        pix_data  = hflip_p1 ? row_p2[pix_col] : row_p2[COL_MAX - pix_col];
        req_ready = pix_last && pix_ready;
      end
      default: ;
    endcase
  end

  // Stage 1 -> 2: ROM word captured into the row register, then shifted out
  always_ff @(posedge clk) begin
    if (reset) begin
      hflip_p1 <= 1'b0;
      oob_p1   <= 1'b0;
      row_p2   <= '0;
      pix_col  <= '0;
    end else begin
      if (accept) begin
        hflip_p1 <= req_hflip;
        oob_p1   <= req_oob;
      end
      if (state == FETCH) begin
        row_p2  <= oob_p1 ? '0 : rom_row_p1;
        pix_col <= '0;
      end else if (pix_valid && pix_ready) begin
        pix_col <= pix_last ? '0 : pix_col + COL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_row_streamer.sv
// Bench for sprite_row_streamer: directed rows, back-to-back, mid-row reset
// and randomized requests with random backpressure against a row model.
module tb_sprite_row_streamer;
  import sprite_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_code;
  logic [ROW_W-1:0]  req_row;
  logic              req_hflip;
  logic              req_vflip;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic [COL_W-1:0]  pix_col;
  logic              pix_last;
  logic              err_oob;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  sprite_row_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_code (req_code),
    .req_row  (req_row),
    .req_hflip(req_hflip),
    .req_vflip(req_vflip),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .pix_col  (pix_col),
    .pix_last (pix_last),
    .err_oob  (err_oob),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_oob(input int code, input int row);
    return (code >= NUM_GLYPHS) || (row >= GLYPH_H);
  endfunction

  // Screen-order pixels: bit 23 is the first pixel streamed.
  function automatic logic [23:0] model_row(input int code, input int row, input bit hf, input bit vf);
    logic [23:0] w;
    logic [23:0] r;
    if (model_oob(code, row)) return '0;
    w = glyph_row(code, vf ? (GLYPH_H - 1 - row) : row);
    if (!hf) return w;
    for (int i = 0; i < 24; i++) r[23-i] = w[i];
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({"idle_busy_", tag},  32'(busy), 32'd0);
    check({"idle_valid_", tag}, 32'(pix_valid), 32'd0);
    check({"idle_ready_", tag}, 32'(req_ready), 32'd1);
  endtask

  // mode 0: always ready, 1: stall 3 cycles at stall_at, 2: random backpressure
  task automatic stream_row(input int code, input int row, input bit hf, input bit vf,
                            input int mode, input int stall_at, input logic [23:0] exp,
                            input string tag);
    logic [23:0] bits;
    int got, cyc, col_err, hold_err, drop_err, stall_left;
    bits = '0; got = 0; cyc = 0; col_err = 0; hold_err = 0; drop_err = 0; stall_left = 3;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_code  = CODE_W'(code);
    req_row   = ROW_W'(row);
    req_hflip = hf;
    req_vflip = vf;
    pix_ready = 1'b1;
    @(negedge clk);
    check({"ready_", tag}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check({"fetch_valid_", tag}, 32'(pix_valid), 32'd0);
    check({"oob_", tag}, 32'(err_oob), 32'(model_oob(code, row)));
    while (got < 24 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 1 && pix_valid && pix_col == COL_W'(stall_at) && stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else if (mode == 2) begin
        pix_ready = ($urandom_range(0, 3) != 0);
      end else begin
        pix_ready = 1'b1;
      end
      @(negedge clk);
      if (cyc == 1) begin
        check({"latency_", tag}, 32'(pix_valid), 32'd1);
        check({"oob_pulse_", tag}, 32'(err_oob), 32'd0);
      end
      if (!pix_valid) drop_err++;
      else if (!pix_ready) begin
        if (pix_col !== COL_W'(got) || pix_data !== exp[23-got]) hold_err++;
      end else begin
        if (pix_col !== COL_W'(got)) col_err++;
        if (pix_last !== (got == 23)) col_err++;
        bits[23-got] = pix_data;
        got++;
      end
    end
    check({"count_", tag}, 32'(got), 32'd24);
    check({"row_", tag}, 32'(bits), 32'(exp));
    check({"cols_", tag}, 32'(col_err), 32'd0);
    check({"hold_", tag}, 32'(hold_err), 32'd0);
    check({"nodrop_", tag}, 32'(drop_err), 32'd0);
    if (mode == 1) check({"stalled_", tag}, 32'(stall_left), 32'd0);
    @(posedge clk); #1;
    pix_ready = 1'b1;
    @(negedge clk);
    check_idle(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] seq;
    int n, first_a, first_b, last_a, acc_cyc;
    bit found;
    reset = 1'b1; req_valid = 1'b0; req_code = '0; req_row = '0;
    req_hflip = 1'b0; req_vflip = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({pix_valid, pix_data, pix_col, pix_last, err_oob, busy}), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    stream_row(GLY_SOLID, 7, 0, 0, 0, 0, 24'hFFFFFF, "solid");
    stream_row(GLY_FROG_UP, 1, 0, 0, 0, 0, 24'b001110000000000000011110, "frog1");
    stream_row(GLY_FROG_UP, 1, 1, 0, 0, 0, 24'b011110000000000000011100, "frog1_h");
    stream_row(GLY_FROG_UP, 1, 0, 1, 0, 0, 24'b011110000000000000011110, "frog1_v");
    stream_row(GLY_FROG_DOWN, 0, 0, 1, 0, 0, 24'b011110000000000000011110, "frogdn_v");
    stream_row(GLY_COLON, 7, 0, 0, 1, 5, model_row(GLY_COLON, 7, 0, 0), "colon_stall");
    stream_row(13, 0, 0, 0, 0, 0, 24'h000000, "oob_code");
    stream_row(GLY_SOLID, 22, 0, 0, 0, 0, 24'h000000, "oob_row");

    // Back-to-back: second request held valid through the first row
    @(posedge clk); #1;
    req_valid = 1'b1; req_code = CODE_W'(GLY_SOLID); req_row = 5'd3;
    req_hflip = 1'b0; req_vflip = 1'b0; pix_ready = 1'b1;
    @(posedge clk); #1;
    req_code = CODE_W'(GLY_FROG_UP); req_row = 5'd1;
    seq = '0; n = 0; first_a = -1; first_b = -1; last_a = -1; acc_cyc = -1;
    for (int c = 0; c < 80 && n < 48; c++) begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        if (n == 0)  first_a = c;
        if (n == 23) last_a  = c;
        if (n == 24) first_b = c;
        seq[47-n] = pix_data;
        n++;
      end
      if (req_valid && req_ready && acc_cyc < 0) acc_cyc = c;
      @(posedge clk); #1;
      if (acc_cyc >= 0) req_valid = 1'b0;
    end
    check("b2b_count", 32'(n), 32'd48);
    check("b2b_row_a", 32'(seq[47:24]), 32'hFFFFFF);
    check("b2b_row_b", 32'(seq[23:0]), 32'(24'b001110000000000000011110));
    check("b2b_accept_on_last", 32'(acc_cyc), 32'(last_a));
    check("b2b_first_b_latency", 32'(first_b - acc_cyc), 32'd2);
    check("b2b_period", 32'(first_b - first_a), 32'd25);
    @(negedge clk);
    check_idle("b2b");

    // Reset in the middle of a row
    @(posedge clk); #1;
    req_valid = 1'b1; req_code = CODE_W'(GLY_SOLID); req_row = 5'd0; pix_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (pix_valid && pix_col == COL_W'(10)) found = 1'b1;
    end
    check("rst_reach_col10", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 32'({pix_valid, pix_data, pix_col, pix_last, err_oob, busy}), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("midrst_no_more_pixels", 32'(pix_valid), 32'd0);
    stream_row(GLY_FROG_UP, 1, 0, 0, 0, 0, 24'b001110000000000000011110, "after_rst");

    // Randomized requests with random backpressure
    for (int i = 0; i < 30; i++) begin
      int code, row;
      bit hf, vf;
      code = $urandom_range(0, 15);
      row  = $urandom_range(0, 25);
      hf   = 1'($urandom_range(0, 1));
      vf   = 1'($urandom_range(0, 1));
      stream_row(code, row, hf, vf, 2, 0, model_row(code, row, hf, vf), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_row_streamer.md
Name: sprite_row_streamer

Overview:
Parametrised successor to the combinational glyph ROM. It holds GLYPH_W-wide, GLYPH_H-tall glyphs in a registered synchronous ROM and streams one selected glyph row out one pixel per handshake, leftmost pixel first. It adds per-request horizontal and vertical mirroring and out-of-range detection. It sits between the sprite/text layer and the VGA pixel path.

Parameters:
GLYPH_W, 24, pixels per glyph row (ROM word width)
GLYPH_H, 22, rows per glyph
NUM_GLYPHS, 13, number of glyphs stored (codes 0..NUM_GLYPHS-1)
CODE_W, 4, width of glyph code input
ROW_W, 5, width of row index input ($clog2(GLYPH_H))
COL_W, 5, width of column output ($clog2(GLYPH_W))

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high
req_valid  in  1  row request present
req_ready  out  1  streamer can accept a request
req_code  in  CODE_W  glyph code
req_row  in  ROW_W  row within glyph, 0 = top
req_hflip  in  1  mirror left/right
req_vflip  in  1  mirror top/bottom
pix_valid  out  1  pix_data valid
pix_ready  in  1  consumer takes pixel
pix_data  out  1  pixel value, 1 = foreground
pix_col  out  COL_W  screen-order column of current pixel, 0..GLYPH_W-1
pix_last  out  1  high with column GLYPH_W-1
err_oob  out  1  one-cycle pulse: accepted request had out-of-range code or row
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state IDLE; pix_valid, pix_data, pix_col, pix_last, err_oob, busy all 0. The latched flip flags and shift register clear. Reset mid-stream abandons the row and emits no further pixels.
- FSM states IDLE, FETCH, SHIFT.
- req_ready = (state==IDLE) || (state==SHIFT && pix_last && pix_ready). This is combinational on pix_ready.
- Accept = req_valid && req_ready. On accept:
  - latch hflip.
  - compute eff_row = vflip ? GLYPH_H-1-req_row : req_row.
  - drive ROM address = req_code*GLYPH_H + eff_row.
  - go to FETCH.
- Out of range: req_code >= NUM_GLYPHS or req_row >= GLYPH_H.
  - The request is still accepted and err_oob pulses high in the FETCH cycle.
  - The row data is forced to all zeros, so GLYPH_W zero pixels are streamed.
- FETCH (exactly 1 cycle): the ROM registered output is valid. At the end of the cycle it is loaded into the row register, pix_col is set to 0, and the FSM goes to SHIFT.
- SHIFT:
  - pix_valid = 1.
  - pix_data = hflip ? row[pix_col] : row[GLYPH_W-1-pix_col]. The MSB of the ROM word is the leftmost unflipped pixel.
- Handshake: on pix_valid && pix_ready, pix_col increments.
  - While pix_ready = 0, pix_data and pix_col hold.
  - pix_valid never drops mid-row.
- Last pixel: pix_last = (pix_col == GLYPH_W-1). When the last pixel transfers:
  - with a simultaneous accept, go to FETCH (throughput GLYPH_W+1 cycles/row).
  - otherwise go to IDLE.
- Latency: accept at edge t; FETCH during cycle t+1; first pix_valid in cycle t+2.
- Requests arriving while req_ready = 0 are ignored. The requester holds them stable per valid/ready rules.

Decomposition:
- Package sprite_pkg holds:
  - GLYPH_W, GLYPH_H, NUM_GLYPHS defaults.
  - glyph code constants: GLY_BLANK=0, GLY_FROG_UP=1, GLY_FROG_DOWN=2, GLY_FROG_R=3, GLY_FROG_L=4, GLY_S=5, GLY_C=6, GLY_O=7, GLY_R=8, GLY_E=9, GLY_COLON=10, GLY_ZERO=11, GLY_SOLID=12.
  - streamer state enum typedef.
- One sub-module, glyph_rom: a synchronous read ROM with 1-cycle latency, parametrised by width, depth, and the ROM contents parameter. It outputs zeros for address >= NUM_GLYPHS*GLYPH_H.

Test Plan:
- Code 12, row 7, no flip, pix_ready = 1 -> pix_valid in 2nd cycle after accept; 24 consecutive 1s; pix_last with pix_col = 23; back to IDLE.
- Code 1, row 1, no flip -> stream 001110000000000000011110. The same request with hflip = 1 -> 011110000000000000011100.
- Code 1, row 1, vflip = 1 (fetches row 20) -> 011110000000000000011110. Code 2, row 0, vflip = 1 -> 011110000000000000011110.
- Code 10, row 7; drop pix_ready for 3 cycles at pix_col = 5 -> pix_col and pix_data held. Resumes with pix_col = 6 after release; 24 pixels total, no duplicates or drops.
- Code 13 (out of range) and separately row 22 -> err_oob single-cycle pulse in FETCH; 24 zero pixels streamed.
- Back-to-back: second request held valid during the first row -> accepted on the last-pixel cycle; next pix_valid 2 cycles later (25-cycle row period).
- Reset asserted at pix_col = 10 -> next cycle IDLE with all outputs 0 and req_ready = 1; the following request streams correctly from column 0.
